// File: rtl/uc_pkg.sv
// Shared definitions for the sequential control unit: register-control and
// ALU encodings, opcode constants, FSM state type and a small decode helper.
// Imported by uc_rep_counter and unidade_de_controle_seq.
package uc_pkg;

   // Register-control field encodings (tx/ty/tz)
   localparam int CTL_HOLD   = 0;
   localparam int CTL_LOAD   = 1;
   localparam int CTL_SHIFTR = 2;
   localparam int CTL_SHIFTL = 3;
   localparam int CTL_RESET  = 4;

   // ALU control encodings (tula)
   localparam int ALU_HOLD = 0;
   localparam int ALU_ADD  = 1;

   // Opcodes, decoded from the low three opcode bits only
   localparam logic [2:0] OP_CLRLD   = 3'b000;
   localparam logic [2:0] OP_ADDLD   = 3'b001;
   localparam logic [2:0] OP_ADD     = 3'b010;
   localparam logic [2:0] OP_DIV2N   = 3'b011;
   localparam logic [2:0] OP_DISPLAY = 3'b100;
   localparam logic [2:0] OP_MUL2N   = 3'b101;
   localparam logic [2:0] OP_CLRALL  = 3'b110;
   localparam logic [2:0] OP_NOP     = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   // Shift opcodes are the only multi-cycle instructions
   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_DIV2N) || (op == OP_MUL2N);
   endfunction

endpackage

// File: rtl/uc_rep_counter.sv
// Repeat counter: holds the number of execute cycles still to run, including
// the current one. Ports: clk, rst (sync, active-high), load/load_val (start a
// new instruction), dec (advance one cycle), last (current cycle is final).
module uc_rep_counter
   import uc_pkg::*;
#(
   parameter int CNTW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [CNTW-1:0] load_val,
   input  logic            dec,
   output logic            last
);

   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNTW'(1);
      end
   end

   assign last = (cnt == CNTW'(1));

endmodule

// File: rtl/unidade_de_controle_seq.sv
// Sequential control unit: accepts one instruction at a time when idle and
// drives registered register/ALU control fields for one or more execute cycles.
// Ports: clk, rst (sync, active-high), instr_valid/instr_ready handshake,
// opcode/count/status (sampled on accept), tx/ty/tz/tula controls,
// done (final execute cycle), skipped (instruction suppressed, with done).
// Optional build macro UC_STATUS_GATE_EN: ADDLD/ADD accepted with status==1
// run as a single all-HOLD cycle flagged with skipped.
module unidade_de_controle_seq
   import uc_pkg::*;
#(
   parameter int OPW  = 3,
   parameter int CNTW = 4,
   parameter int CTW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [OPW-1:0]  opcode,
   input  logic [CNTW-1:0] count,
   input  logic            status,
   output logic [CTW-1:0]  tx,
   output logic [CTW-1:0]  ty,
   output logic [CTW-1:0]  tz,
   output logic [CTW-1:0]  tula,
   output logic            done,
   output logic            skipped
);

   localparam logic [CTW-1:0] HOLD = CTW'(CTL_HOLD);

   state_t          state, state_nxt;
   logic [CTW-1:0]  tx_q, ty_q, tz_q, tula_q;
   logic [CTW-1:0]  tx_n, ty_n, tz_n, tula_n;
   logic            skip_q, skip_n;

   // Decoded view of the offered instruction
   logic [2:0]      op;
   logic [CTW-1:0]  tx_d, ty_d, tz_d, tula_d;
   logic [CNTW-1:0] len_d;
   logic            skip_d;

   logic            accept;
   logic            cnt_load, cnt_dec, cnt_last;

   assign op          = opcode[2:0];
   assign instr_ready = (state == ST_IDLE);
   assign accept      = instr_valid && instr_ready;

   // Suppression decision for the status-gated build
`ifdef UC_STATUS_GATE_EN
   assign skip_d = status && ((op == OP_ADDLD) || (op == OP_ADD));
`else
   // status has no effect in this build
   assign skip_d = status & 1'b0;
`endif

   always_comb begin
      tx_d   = HOLD;
      ty_d   = HOLD;
      tz_d   = HOLD;
      tula_d = CTW'(ALU_HOLD);
      // A zero count on a shift still runs one cycle
      len_d  = (is_shift(op) && (count != '0)) ? count : CNTW'(1);
      if (!skip_d) begin
         case (op)
            OP_CLRLD: begin
               ty_d = CTW'(CTL_RESET);
               tx_d = CTW'(CTL_LOAD);
               tz_d = CTW'(CTL_RESET);
            end
            OP_ADDLD: begin
               ty_d   = CTW'(CTL_LOAD);
               tx_d   = CTW'(CTL_LOAD);
               tula_d = CTW'(ALU_ADD);
            end
            OP_ADD: begin
               ty_d   = CTW'(CTL_LOAD);
               tula_d = CTW'(ALU_ADD);
            end
            OP_DIV2N:   ty_d = CTW'(CTL_SHIFTR);
            OP_DISPLAY: tz_d = CTW'(CTL_LOAD);
            OP_MUL2N:   ty_d = CTW'(CTL_SHIFTL);
            OP_CLRALL: begin
               tx_d = CTW'(CTL_RESET);
               ty_d = CTW'(CTL_RESET);
               tz_d = CTW'(CTL_RESET);
            end
            default: ;  // NOP: everything holds
         endcase
      end
   end

   // Next-state and next-control logic. Controls are loaded on the accept
   // edge so they are already valid in the first execute cycle.
   always_comb begin
      state_nxt = state;
      tx_n      = tx_q;
      ty_n      = ty_q;
      tz_n      = tz_q;
      tula_n    = tula_q;
      skip_n    = skip_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_n   = HOLD;
            ty_n   = HOLD;
            tz_n   = HOLD;
            tula_n = CTW'(ALU_HOLD);
            skip_n = 1'b0;
            if (accept) begin
               state_nxt = ST_EXEC;
               tx_n      = tx_d;
               ty_n      = ty_d;
               tz_n      = tz_d;
               tula_n    = tula_d;
               skip_n    = skip_d;
               cnt_load  = 1'b1;
            end
         end
         ST_EXEC: begin
            if (cnt_last) begin
               state_nxt = ST_IDLE;
               tx_n      = HOLD;
               ty_n      = HOLD;
               tz_n      = HOLD;
               tula_n    = CTW'(ALU_HOLD);
               skip_n    = 1'b0;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         tx_q   <= HOLD;
         ty_q   <= HOLD;
         tz_q   <= HOLD;
         tula_q <= CTW'(ALU_HOLD);
         skip_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         tx_q   <= tx_n;
         ty_q   <= ty_n;
         tz_q   <= tz_n;
         tula_q <= tula_n;
         skip_q <= skip_n;
      end
   end

   uc_rep_counter #(.CNTW(CNTW)) u_rep_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (len_d),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   assign tx      = tx_q;
   assign ty      = ty_q;
   assign tz      = tz_q;
   assign tula    = tula_q;
   // Both derive from registered state only
   assign done    = (state == ST_EXEC) && cnt_last;
   assign skipped = done && skip_q;

endmodule

// File: tb/tb_unidade_de_controle_seq.sv
// Directed bench for unidade_de_controle_seq: reset, each opcode, multi-cycle
// shifts, reset mid-execute, reset-vs-accept priority and status gating.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_unidade_de_controle_seq;

   localparam int OPW  = 3;
   localparam int CNTW = 4;
   localparam int CTW  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            instr_valid;
   logic            instr_ready;
   logic [OPW-1:0]  opcode;
   logic [CNTW-1:0] count;
   logic            status;
   logic [CTW-1:0]  tx, ty, tz, tula;
   logic            done, skipped;

   int n_checks = 0;
   int n_pass   = 0;

   unidade_de_controle_seq #(.OPW(OPW), .CNTW(CNTW), .CTW(CTW)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .count       (count),
      .status      (status),
      .tx          (tx),
      .ty          (ty),
      .tz          (tz),
      .tula        (tula),
      .done        (done),
      .skipped     (skipped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ready"},   32'(instr_ready), 32'd1);
      check({tag, " tx"},      32'(tx),          32'd0);
      check({tag, " ty"},      32'(ty),          32'd0);
      check({tag, " tz"},      32'(tz),          32'd0);
      check({tag, " tula"},    32'(tula),        32'd0);
      check({tag, " done"},    32'(done),        32'd0);
      check({tag, " skipped"}, 32'(skipped),     32'd0);
   endtask

   // Single-cycle instruction: one execute cycle with done, then idle
   task automatic run1(input string tag, input logic [2:0] op, input logic st,
                       input int etx, input int ety, input int etz, input int etula,
                       input int eskip);
      instr_valid = 1'b1;
      opcode      = op;
      count       = 4'd7;
      status      = st;
      step();
      instr_valid = 1'b0;
      status      = ~st;  // later status changes must not matter
      check({tag, " tx"},      32'(tx),          32'(etx));
      check({tag, " ty"},      32'(ty),          32'(ety));
      check({tag, " tz"},      32'(tz),          32'(etz));
      check({tag, " tula"},    32'(tula),        32'(etula));
      check({tag, " done"},    32'(done),        32'd1);
      check({tag, " skipped"}, 32'(skipped),     32'(eskip));
      check({tag, " ready"},   32'(instr_ready), 32'd0);
      step();
      check_idle({tag, " after"});
   endtask

   // Shift instruction with instr_valid held through execute
   task automatic run_shift(input string tag, input logic [2:0] op, input logic [3:0] cnt,
                            input int ety, input int elen);
      instr_valid = 1'b1;
      opcode      = op;
      count       = cnt;
      status      = 1'b0;
      for (int i = 0; i < elen; i++) begin
         step();
         count = 4'd2;  // changed count must not reload anything
         check($sformatf("%s c%0d ty", tag, i),    32'(ty),          32'(ety));
         check($sformatf("%s c%0d tx", tag, i),    32'(tx),          32'd0);
         check($sformatf("%s c%0d done", tag, i),  32'(done),        32'(i == elen - 1));
         check($sformatf("%s c%0d ready", tag, i), 32'(instr_ready), 32'd0);
      end
      instr_valid = 1'b0;
      step();
      check_idle({tag, " after"});
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      opcode      = '0;
      count       = '0;
      status      = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_idle("reset");
      step();
      check_idle("idle");

      // ADD: controls only at t+1, ready again at t+2
      run1("add",     3'b010, 1'b0, 0, 1, 0, 1, 0);
      run1("clrld",   3'b000, 1'b0, 1, 4, 4, 0, 0);
      run1("addld",   3'b001, 1'b0, 1, 1, 0, 1, 0);
      run1("display", 3'b100, 1'b0, 0, 0, 1, 0, 0);
      run1("clrall",  3'b110, 1'b0, 4, 4, 4, 0, 0);
      run1("nop",     3'b111, 1'b0, 0, 0, 0, 0, 0);

      // Status-gated ADDLD / ADD
`ifdef UC_STATUS_GATE_EN
      run1("addld_st", 3'b001, 1'b1, 0, 0, 0, 0, 1);
      run1("add_st",   3'b010, 1'b1, 0, 0, 0, 0, 1);
`else
      run1("addld_st", 3'b001, 1'b1, 1, 1, 0, 1, 0);
      run1("add_st",   3'b010, 1'b1, 0, 1, 0, 1, 0);
`endif

      // Shifts: normal, zero count, maximum count
      run_shift("div2n5",   3'b011, 4'd5,  2, 5);
      run_shift("mul2n0",   3'b101, 4'd0,  3, 1);
      run_shift("mul2n15",  3'b101, 4'd15, 3, 15);

      // Reset during cycle 2 of DIV2N count=4 aborts without done
      instr_valid = 1'b1;
      opcode      = 3'b011;
      count       = 4'd4;
      step();
      instr_valid = 1'b0;
      check("abort c1 ty", 32'(ty), 32'd2);
      step();
      check("abort c2 ty",   32'(ty),   32'd2);
      check("abort c2 done", 32'(done), 32'd0);
      rst = 1'b1;
      step();
      check("abort rst ty",   32'(ty),   32'd0);
      check("abort rst done", 32'(done), 32'd0);
      rst = 1'b0;
      step();
      check_idle("abort after");

      // Reset wins over a simultaneous accept
      rst         = 1'b1;
      instr_valid = 1'b1;
      opcode      = 3'b010;
      step();
      rst         = 1'b0;
      instr_valid = 1'b0;
      check_idle("rst_prio");
      step();
      check_idle("rst_prio after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/unidade_de_controle_seq.md
UNIDADE_DE_CONTROLE_SEQ -- requirements
Module: unidade_de_controle_seq

Interface
REQ-001 SHALL have parameter OPW, default 3, opcode width (min 3).
REQ-002 SHALL have parameter CNTW, default 4, repeat-count width.
REQ-003 SHALL have parameter CTW, default 3, width of each register-control field.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit idle, can accept.
- opcode  in  OPW  operation, sampled on accept.
- count  in  CNTW  shift repeat count, sampled on accept.
- status  in  1  datapath status flag, sampled on accept.
- tx, ty, tz  out  CTW  register X/Y/Z control (HOLD=0, LOAD=1, SHIFTR=2, SHIFTL=3, RESET=4).
- tula  out  CTW  ALU control (HOLD=0, ADD=1).
- done  out  1  one-cycle pulse on the last execute cycle.
- skipped  out  1  valid with done; instruction suppressed.

Function
REQ-005 SHALL use states IDLE and EXEC only.
REQ-006 SHALL assert instr_ready iff state==IDLE; accept = instr_valid && instr_ready.
REQ-007 SHALL, on accept at edge t, latch opcode/count/status, enter EXEC, and drive controls from cycle t+1.
REQ-008 SHALL decode opcode[2:0] (upper bits ignored):
- 000 CLRLD: ty=RESET, tx=LOAD, tz=RESET, 1 cycle.
- 001 ADDLD: ty=LOAD, tx=LOAD, tula=ADD, 1 cycle.
- 010 ADD: ty=LOAD, tula=ADD, 1 cycle.
- 011 DIV2N: ty=SHIFTR for max(count,1) cycles.
- 100 DISPLAY: tz=LOAD, 1 cycle.
- 101 MUL2N: ty=SHIFTL for max(count,1) cycles.
- 110 CLRALL: tx=ty=tz=RESET, 1 cycle.
- 111 NOP: all HOLD, 1 cycle.
REQ-009 SHALL hold unlisted fields at HOLD in every cycle.
REQ-010 SHALL keep all control outputs registered; in IDLE all fields equal HOLD.
REQ-011 SHALL pulse done during the final EXEC cycle and return to IDLE on the following edge; instr_ready rises the cycle after done.
REQ-012 SHALL accept no instruction in EXEC; instr_valid there is ignored and must be held by the source.
REQ-013 SHALL treat count==0 for shifts as count==1; maximum count is 2^CNTW-1 cycles, with no wrap.
REQ-014 SHALL ignore status changes after accept.
REQ-015 SHALL drive skipped=0 whenever done=0.

Reset
REQ-016 SHALL on rst==1 at a clock edge force state IDLE, tx=ty=tz=tula=HOLD, done=0, skipped=0, and the repeat counter to 0.
REQ-017 SHALL let reset mid-EXEC abort the instruction with no done pulse; instr_ready=1 the cycle after rst deasserts.
REQ-018 SHALL let rst take priority over accept in the same cycle.

Configuration
REQ-019 SHALL, with UC_STATUS_GATE_EN defined, execute ADDLD/ADD accepted with status==1 as one all-HOLD cycle with done=1, skipped=1.
REQ-020 SHALL, without UC_STATUS_GATE_EN, ignore status entirely; skipped stays 0.

Structure
REQ-021 SHALL place the control encodings HOLD/LOAD/SHIFTR/SHIFTL/RESET, the ALU codes, the opcode constants and the state enum in package uc_pkg.
REQ-022 SHALL implement the repeat counter as sub-module uc_rep_counter (load, decrement, last flag); the rest stays flat.

Verification
REQ-023 SHALL cover the following directed scenarios:
- Reset then idle -> instr_ready=1, all controls 0, done=0.
- ADD accepted at t -> ty=1, tula=1 at t+1 only, done at t+1, instr_ready at t+2.
- DIV2N, count=5 -> ty=2 for cycles t+1..t+5, done at t+5 only; instr_valid held during EXEC is not re-accepted.
- MUL2N, count=0 -> ty=3 for exactly one cycle, done=1.
- rst asserted at cycle 2 of DIV2N count=4 -> controls HOLD the next cycle, no done pulse.
- With UC_STATUS_GATE_EN, ADDLD accepted with status=1 -> all HOLD, done=1, skipped=1; without the macro -> tx=ty=1, skipped=0.
